speicher_busarbiter: RTL and testbench

//  Downstream of the CPU memory interface: serialises the CPU's instruction-fetch, data-load and

---
 rtl/speicher_busarbiter.sv | 128 ++++++++++++
 tb/tb_speicher_busarbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/speicher_busarbiter.sv
// Serialises CPU fetch/load/store requests onto one single-port, variable-latency memory bus.
// Latency: strobe one cycle after the request is sampled, completion pulse one cycle after SpeicherBereit.
// Backpressure: requests are levels held by the CPU; losers wait, and a one-cycle SPERRE gap follows each access.
module speicher_busarbiter #(
  parameter int ADRESS_BREITE = 32,
  parameter int DATEN_BREITE  = 32,
  parameter int ZEITLIMIT     = 255
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [ADRESS_BREITE-1:0] InstruktionAdresse,
  input  logic                     LeseInstruktion,
  output logic [DATEN_BREITE-1:0]  Instruktion,
  output logic                     InstruktionGeladen,
  input  logic [ADRESS_BREITE-1:0] DatenAdresse,
  input  logic [DATEN_BREITE-1:0]  DatenRaus,
  input  logic                     LeseDaten,
  input  logic                     SchreibeDaten,
  output logic [DATEN_BREITE-1:0]  DatenRein,
  output logic                     DatenGeladen,
  output logic                     DatenGespeichert,
  output logic [ADRESS_BREITE-1:0] SpeicherAdresse,
  output logic [DATEN_BREITE-1:0]  SpeicherSchreibDaten,
  output logic                     SpeicherLesen,
  output logic                     SpeicherSchreiben,
  input  logic [DATEN_BREITE-1:0]  SpeicherLeseDaten,
  input  logic                     SpeicherBereit,
  output logic                     Fehler
);

  // A disabled watchdog still needs a one-bit counter so the design elaborates cleanly.
  localparam int ZAEHLER_BREITE = (ZEITLIMIT > 0) ? $clog2(ZEITLIMIT + 1) : 1;
  localparam logic [ZAEHLER_BREITE-1:0] ZAEHLER_MAX =
    (ZEITLIMIT > 0) ? ZAEHLER_BREITE'(ZEITLIMIT) : {ZAEHLER_BREITE{1'b1}};

  typedef enum logic [2:0] {
    LEERLAUF,
    INSTR_LESEN,
    DATEN_LESEN,
    DATEN_SCHREIBEN,
    SPERRE
  } zustand_t;

  zustand_t                  zustand;
  logic [ZAEHLER_BREITE-1:0] zaehler;
  logic                      zeitUeberschritten;

  // The watchdog fires in the strobe cycle where the counter would reach ZEITLIMIT, so the strobe is
  // high for exactly ZEITLIMIT cycles; a Bereit arriving in that same cycle still wins.
  always_comb begin
    zeitUeberschritten = (ZEITLIMIT > 0) && (zaehler == ZAEHLER_MAX - 1'b1);
  end

  // Arbitration, bus strobes, watchdog and completion pulses, all registered.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      zustand              <= LEERLAUF;
      zaehler              <= '0;
      Instruktion          <= '0;
      InstruktionGeladen   <= 1'b0;
      DatenRein            <= '0;
      DatenGeladen         <= 1'b0;
      DatenGespeichert     <= 1'b0;
      SpeicherAdresse      <= '0;
      SpeicherSchreibDaten <= '0;
      SpeicherLesen        <= 1'b0;
      SpeicherSchreiben    <= 1'b0;
      Fehler               <= 1'b0;
    end else begin
      InstruktionGeladen <= 1'b0;
      DatenGeladen       <= 1'b0;
      DatenGespeichert   <= 1'b0;

      case (zustand)
        LEERLAUF: begin
          zaehler <= '0;
          if (SchreibeDaten) begin
            SpeicherAdresse      <= DatenAdresse;
            SpeicherSchreibDaten <= DatenRaus;
            SpeicherSchreiben    <= 1'b1;
            zustand              <= DATEN_SCHREIBEN;
          end else if (LeseDaten) begin
            SpeicherAdresse <= DatenAdresse;
            SpeicherLesen   <= 1'b1;
            zustand         <= DATEN_LESEN;
          end else if (LeseInstruktion) begin
            SpeicherAdresse <= InstruktionAdresse;
            SpeicherLesen   <= 1'b1;
            zustand         <= INSTR_LESEN;
          end
        end

        INSTR_LESEN, DATEN_LESEN, DATEN_SCHREIBEN: begin
          if (zaehler != ZAEHLER_MAX) begin
            zaehler <= zaehler + 1'b1;
          end
          if (SpeicherBereit || zeitUeberschritten) begin
            SpeicherLesen     <= 1'b0;
            SpeicherSchreiben <= 1'b0;
            zustand           <= SPERRE;
            if (!SpeicherBereit) begin
              Fehler <= 1'b1;
            end
            // An aborted read still completes towards the CPU, but with a zero word.
            if (zustand == INSTR_LESEN) begin
              InstruktionGeladen <= 1'b1;
              Instruktion        <= SpeicherBereit ? SpeicherLeseDaten : '0;
            end else if (zustand == DATEN_LESEN) begin
              DatenGeladen <= 1'b1;
              DatenRein    <= SpeicherBereit ? SpeicherLeseDaten : '0;
            end else begin
              DatenGespeichert <= 1'b1;
            end
          end
        end

        SPERRE: begin
          zustand <= LEERLAUF;
        end

        default: begin
          zustand <= LEERLAUF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_speicher_busarbiter.sv
module tb_speicher_busarbiter;

  localparam int ZL = 4;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] InstruktionAdresse;
  logic        LeseInstruktion;
  logic [31:0] Instruktion;
  logic        InstruktionGeladen;
  logic [31:0] DatenAdresse;
  logic [31:0] DatenRaus;
  logic        LeseDaten;
  logic        SchreibeDaten;
  logic [31:0] DatenRein;
  logic        DatenGeladen;
  logic        DatenGespeichert;
  logic [31:0] SpeicherAdresse;
  logic [31:0] SpeicherSchreibDaten;
  logic        SpeicherLesen;
  logic        SpeicherSchreiben;
  logic [31:0] SpeicherLeseDaten;
  logic        SpeicherBereit;
  logic        Fehler;

  int checks = 0;
  int errors = 0;

  // Reference state: what the CPU-side outputs must hold between completions.
  logic [31:0] expInstr;
  logic [31:0] expDaten;
  logic        expFehler;

  speicher_busarbiter #(
    .ADRESS_BREITE(32),
    .DATEN_BREITE (32),
    .ZEITLIMIT    (ZL)
  ) dut (
    .Clock               (Clock),
    .Reset               (Reset),
    .InstruktionAdresse  (InstruktionAdresse),
    .LeseInstruktion     (LeseInstruktion),
    .Instruktion         (Instruktion),
    .InstruktionGeladen  (InstruktionGeladen),
    .DatenAdresse        (DatenAdresse),
    .DatenRaus           (DatenRaus),
    .LeseDaten           (LeseDaten),
    .SchreibeDaten       (SchreibeDaten),
    .DatenRein           (DatenRein),
    .DatenGeladen        (DatenGeladen),
    .DatenGespeichert    (DatenGespeichert),
    .SpeicherAdresse     (SpeicherAdresse),
    .SpeicherSchreibDaten(SpeicherSchreibDaten),
    .SpeicherLesen       (SpeicherLesen),
    .SpeicherSchreiben   (SpeicherSchreiben),
    .SpeicherLeseDaten   (SpeicherLeseDaten),
    .SpeicherBereit      (SpeicherBereit),
    .Fehler              (Fehler)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running want finished");
    $fatal(1, "global timeout");
  end

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  // One arbitration round: the CPU raises any subset of requests at once; the memory model answers
  // each access after lat+1 strobe cycles. Expected order, durations, timing and data come from the
  // priority rule (store > load > fetch) and the watchdog limit.
  task automatic run_round(input bit w, input bit l, input bit f,
                           input logic [31:0] aI, input logic [31:0] aD, input logic [31:0] wd,
                           input logic [31:0] rD, input logic [31:0] rI,
                           input int latW, input int latL, input int latF);
    int          kind[3];
    logic [31:0] adr[3];
    logic [31:0] rdat[3];
    int          lat[3];
    int          dur[3];
    bit          tout[3];
    int          n, served, cnt, cycles, lastPulse;
    bit          prevPulse;
    logic [2:0]  pulses, expPulse;
    n = 0;
    if (w) begin kind[n] = 0; adr[n] = aD; rdat[n] = 32'h0; lat[n] = latW; n++; end
    if (l) begin kind[n] = 1; adr[n] = aD; rdat[n] = rD;    lat[n] = latL; n++; end
    if (f) begin kind[n] = 2; adr[n] = aI; rdat[n] = rI;    lat[n] = latF; n++; end
    for (int i = 0; i < n; i++) begin
      tout[i] = (lat[i] + 1 > ZL);
      dur[i]  = tout[i] ? ZL : lat[i] + 1;
    end
    InstruktionAdresse = aI;
    DatenAdresse       = aD;
    DatenRaus          = wd;
    SchreibeDaten      = w;
    LeseDaten          = l;
    LeseInstruktion    = f;
    served = 0; cnt = 0; cycles = 0; lastPulse = 0; prevPulse = 1'b0;
    while (served < n && cycles < 300) begin
      tick();
      cycles++;
      pulses = {DatenGespeichert, DatenGeladen, InstruktionGeladen};
      checks++;
      if (SpeicherLesen && SpeicherSchreiben) begin
        errors++;
        $display("FAIL strobe_overlap: got both strobes high want at most one (cycle %0d)", cycles);
      end
      checks++;
      if (prevPulse && pulses != 3'b000) begin
        errors++;
        $display("FAIL pulse_width: got pulses %b in consecutive cycles want single-cycle pulse", pulses);
      end
      prevPulse = (pulses != 3'b000);
      if (pulses != 3'b000) begin
        expPulse = (kind[served] == 0) ? 3'b100 : (kind[served] == 1) ? 3'b010 : 3'b001;
        checks++;
        if (pulses !== expPulse) begin
          errors++;
          $display("FAIL pulse_kind: got %b want %b", pulses, expPulse);
        end
        checks++;
        if (cycles - lastPulse != dur[served] + ((served == 0) ? 1 : 2)) begin
          errors++;
          $display("FAIL pulse_timing: got %0d cycles want %0d", cycles - lastPulse,
                   dur[served] + ((served == 0) ? 1 : 2));
        end
        checks++;
        if (cnt != dur[served]) begin
          errors++;
          $display("FAIL strobe_length: got %0d cycles want %0d", cnt, dur[served]);
        end
        if (kind[served] == 1) expDaten = tout[served] ? 32'h0 : rdat[served];
        if (kind[served] == 2) expInstr = tout[served] ? 32'h0 : rdat[served];
        if (tout[served]) expFehler = 1'b1;
        checks++;
        if (Instruktion !== expInstr) begin
          errors++;
          $display("FAIL instruktion: got %h want %h", Instruktion, expInstr);
        end
        checks++;
        if (DatenRein !== expDaten) begin
          errors++;
          $display("FAIL datenrein: got %h want %h", DatenRein, expDaten);
        end
        checks++;
        if (Fehler !== expFehler) begin
          errors++;
          $display("FAIL fehler: got %b want %b", Fehler, expFehler);
        end
        if (kind[served] == 0) SchreibeDaten = 1'b0;
        if (kind[served] == 1) LeseDaten = 1'b0;
        if (kind[served] == 2) LeseInstruktion = 1'b0;
        lastPulse = cycles;
        served++;
        cnt = 0;
      end
      if (SpeicherLesen || SpeicherSchreiben) begin
        if (served >= n) begin
          checks++;
          errors++;
          $display("FAIL extra_strobe: got strobe after %0d accesses want none", n);
          SpeicherBereit = 1'b1;
        end else begin
          if (cnt == 0) begin
            checks++;
            if ({SpeicherSchreiben, SpeicherLesen} !== ((kind[served] == 0) ? 2'b10 : 2'b01)) begin
              errors++;
              $display("FAIL strobe_type: got W%b R%b want kind %0d", SpeicherSchreiben, SpeicherLesen,
                       kind[served]);
            end
            checks++;
            if (SpeicherAdresse !== adr[served]) begin
              errors++;
              $display("FAIL address: got %h want %h", SpeicherAdresse, adr[served]);
            end
            if (kind[served] == 0) begin
              checks++;
              if (SpeicherSchreibDaten !== wd) begin
                errors++;
                $display("FAIL write_data: got %h want %h", SpeicherSchreibDaten, wd);
              end
            end
          end
          cnt++;
          SpeicherBereit    = (cnt == lat[served] + 1);
          SpeicherLeseDaten = SpeicherBereit ? rdat[served] : $urandom;
        end
      end else begin
        SpeicherBereit    = 1'($urandom_range(0, 1));
        SpeicherLeseDaten = $urandom;
      end
    end
    checks++;
    if (served != n) begin
      errors++;
      $display("FAIL round_timeout: got %0d completions want %0d", served, n);
    end
    SchreibeDaten = 1'b0; LeseDaten = 1'b0; LeseInstruktion = 1'b0;
    repeat (2) begin
      tick();
      checks++;
      if ({SpeicherLesen, SpeicherSchreiben, DatenGespeichert, DatenGeladen, InstruktionGeladen} !== 5'b0) begin
        errors++;
        $display("FAIL idle: got strobes/pulses %b want 00000",
                 {SpeicherLesen, SpeicherSchreiben, DatenGespeichert, DatenGeladen, InstruktionGeladen});
      end
      SpeicherBereit = 1'($urandom_range(0, 1));
    end
    SpeicherBereit = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({SpeicherLesen, SpeicherSchreiben, InstruktionGeladen, DatenGeladen, DatenGespeichert, Fehler} !== 6'b0) begin
      errors++;
      $display("FAIL %s_ctrl: got %b want 000000", name,
               {SpeicherLesen, SpeicherSchreiben, InstruktionGeladen, DatenGeladen, DatenGespeichert, Fehler});
    end
    checks++;
    if ({Instruktion, DatenRein, SpeicherAdresse, SpeicherSchreibDaten} !== 128'h0) begin
      errors++;
      $display("FAIL %s_data: got %h %h %h %h want all zero", name, Instruktion, DatenRein,
               SpeicherAdresse, SpeicherSchreibDaten);
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    InstruktionAdresse = '0; DatenAdresse = '0; DatenRaus = '0;
    LeseInstruktion = 1'b0; LeseDaten = 1'b0; SchreibeDaten = 1'b0;
    SpeicherLeseDaten = '0; SpeicherBereit = 1'b0;
    repeat (3) tick();
    Reset = 1'b0;
    expInstr = '0; expDaten = '0; expFehler = 1'b0;
    check_all_zero("reset");
    tick();
    check_all_zero("after_reset");
  endtask

  task automatic test_fetch_3cycle;
    run_round(0, 0, 1, 32'h40, 32'h0, 32'h0, 32'h0, 32'h12345678, 0, 0, 2);
  endtask

  task automatic test_store_0wait;
    run_round(1, 0, 0, 32'h0, 32'h100, 32'hCAFEF00D, 32'h0, 32'h0, 0, 0, 0);
  endtask

  task automatic test_priority;
    run_round(1, 1, 1, 32'h200, 32'h300, 32'h11112222, 32'h33334444, 32'h55556666, 1, 0, 2);
  endtask

  task automatic test_watchdog;
    run_round(0, 1, 0, 32'h0, 32'h500, 32'h0, 32'hDEADBEEF, 32'h0, 0, 1000, 0);
    run_round(0, 0, 1, 32'h600, 32'h0, 32'h0, 32'h0, 32'h77778888, 0, 0, 1);
  endtask

  task automatic test_reset_mid_access;
    DatenAdresse = 32'h700;
    LeseDaten = 1'b1;
    SpeicherBereit = 1'b0;
    tick();
    checks++;
    if (SpeicherLesen !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_strobe: got SpeicherLesen=%b want 1", SpeicherLesen);
    end
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    LeseDaten = 1'b0;
    expInstr = '0; expDaten = '0; expFehler = 1'b0;
    check_all_zero("reset_mid");
    SpeicherBereit = 1'b1;
    SpeicherLeseDaten = 32'hBADBAD00;
    repeat (3) begin
      tick();
      check_all_zero("stray_bereit");
    end
    SpeicherBereit = 1'b0;
  endtask

  task automatic test_data_isolation;
    run_round(0, 1, 0, 32'h0, 32'h800, 32'h0, 32'hAAAA5555, 32'h0, 0, 1, 0);
    run_round(0, 0, 1, 32'h900, 32'h0, 32'h0, 32'h0, 32'h0F0F0F0F, 0, 0, 0);
  endtask

  task automatic test_random;
    bit w, l, f;
    for (int r = 0; r < 40; r++) begin
      w = 1'($urandom_range(0, 1));
      l = 1'($urandom_range(0, 1));
      f = 1'($urandom_range(0, 1));
      if (!(w || l || f)) f = 1'b1;
      run_round(w, l, f, $urandom, $urandom, $urandom, $urandom, $urandom,
                $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
    end
  endtask

  task automatic test_back_to_back;
    for (int r = 0; r < 5; r++) begin
      run_round(1, 1, 0, 32'h0, 32'hA00 + r, 32'h1000 + r, 32'h2000 + r, 32'h0, r % 4, (r + 1) % 4, 0);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_3cycle();
    test_store_0wait();
    test_priority();
    test_watchdog();
    test_reset_mid_access();
    test_data_isolation();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
